// File: rtl/bus_fabric_if.sv
// Signal bundle for bus_fabric: source drivers, resolved bus, contention status and trace access.
// The master side drives sources and trace controls; the slave side is the fabric itself.
interface bus_fabric_if #(
    parameter int WIDTH       = 16,
    parameter int NUM_SRC     = 8,
    parameter int TRACE_DEPTH = 16
);
    localparam int IDX_W = $clog2(TRACE_DEPTH);

    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_en;
    logic [WIDTH-1:0]         bus;
    logic                     bus_valid;
    logic                     contention;
    logic                     contention_sticky;
    logic [NUM_SRC-1:0]       contention_src;
    logic                     err_clear;
    logic                     trace_en;
    logic                     trace_clear;
    logic [IDX_W-1:0]         trace_rd_idx;
    logic [WIDTH-1:0]         trace_rd_data;
    logic [IDX_W:0]           trace_count;
    logic                     trace_full;
    logic                     trace_overflow;

    modport master (
        output src_data, src_en, err_clear, trace_en, trace_clear, trace_rd_idx,
        input  bus, bus_valid, contention, contention_sticky, contention_src,
               trace_rd_data, trace_count, trace_full, trace_overflow
    );

    modport slave (
        input  src_data, src_en, err_clear, trace_en, trace_clear, trace_rd_idx,
        output bus, bus_valid, contention, contention_sticky, contention_src,
               trace_rd_data, trace_count, trace_full, trace_overflow
    );
endinterface

// File: rtl/bus_fabric.sv
// Shared-bus fabric: resolves NUM_SRC drivers onto one bus, latches the first contention,
// and keeps an indexed trace of recent bus values for post-halt replay.
module bus_fabric #(
    parameter int WIDTH              = 16,
    parameter int NUM_SRC            = 8,
    parameter int TRACE_DEPTH        = 16,
    parameter int PRIORITY_MODE      = 1,
    parameter int TRACE_STOP_ON_FULL = 0
) (
    input logic         clk,
    input logic         rst,
    bus_fabric_if.slave bif
);
    localparam int IDX_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [WIDTH-1:0]   bus_val;
    logic               any_en;
    logic               multi_en;
    logic               sticky;
    logic [NUM_SRC-1:0] snap;
    logic [WIDTH-1:0]   mem [TRACE_DEPTH];
    logic [IDX_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               overflow;
    logic [WIDTH-1:0]   rd_data;
    logic               capture;
    logic               mem_we;
    logic [IDX_W-1:0]   rd_base;
    logic [IDX_W-1:0]   rd_addr;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        bus_val = '0;
        if (PRIORITY_MODE != 0) begin
            // Walk downward so the lowest enabled index is the last (winning) assignment.
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (bif.src_en[i]) bus_val = bif.src_data[i*WIDTH +: WIDTH];
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bif.src_en[i]) bus_val = bus_val | bif.src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any_en   = |bif.src_en;
    assign multi_en = |(bif.src_en & (bif.src_en - NUM_SRC'(1)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= 1'b0;
            snap   <= '0;
        end else if (bif.err_clear) begin
            sticky <= 1'b0;
            snap   <= '0;
        end else if (multi_en && !sticky) begin
            sticky <= 1'b1;
            snap   <= bif.src_en;
        end
    end

    assign full    = (count == CNT_W'(TRACE_DEPTH));
    assign capture = bif.trace_en & any_en & ~bif.trace_clear;
    assign mem_we  = capture & ~rst & (~full | (TRACE_STOP_ON_FULL == 0));
    assign rd_base = full ? wr_ptr : '0;
    assign rd_addr = rd_base + bif.trace_rd_idx;

    // NOTE: the trace memory has no reset; validity is tracked by count, which keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= bus_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_data <= ({1'b0, bif.trace_rd_idx} < count) ? mem[rd_addr] : '0;
            if (bif.trace_clear) begin
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (capture) begin
                if (!full) begin
                    wr_ptr <= wr_ptr + IDX_W'(1);
                    count  <= count + CNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                    if (TRACE_STOP_ON_FULL == 0) wr_ptr <= wr_ptr + IDX_W'(1);
                end
            end
        end
    end

    assign bif.bus               = bus_val;
    assign bif.bus_valid         = any_en;
    assign bif.contention        = multi_en;
    assign bif.contention_sticky = sticky;
    assign bif.contention_src    = snap;
    assign bif.trace_rd_data     = rd_data;
    assign bif.trace_count       = count;
    assign bif.trace_full        = full;
    assign bif.trace_overflow    = overflow;
endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: one priority/wrap instance and one OR/stop instance,
// with read expectations queued at request time and compared when the data comes back.
module tb_bus_fabric;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    bus_fabric_if #(.WIDTH(16), .NUM_SRC(8), .TRACE_DEPTH(16)) a ();
    bus_fabric_if #(.WIDTH(16), .NUM_SRC(8), .TRACE_DEPTH(16)) b ();

    bus_fabric #(.WIDTH(16), .NUM_SRC(8), .TRACE_DEPTH(16),
                 .PRIORITY_MODE(1), .TRACE_STOP_ON_FULL(0))
        dut_a (.clk(clk), .rst(rst), .bif(a.slave));

    bus_fabric #(.WIDTH(16), .NUM_SRC(8), .TRACE_DEPTH(16),
                 .PRIORITY_MODE(0), .TRACE_STOP_ON_FULL(1))
        dut_b (.clk(clk), .rst(rst), .bif(b.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an index on one instance, queue the expectation, compare after the next edge.
    task automatic read_a(input int idx, input logic [31:0] exp, input string tag);
        a.trace_rd_idx = 4'(idx);
        exp_q.push_back(exp);
        tick();
        check(tag, 32'(a.trace_rd_data), exp_q.pop_front());
    endtask

    task automatic read_b(input int idx, input logic [31:0] exp, input string tag);
        b.trace_rd_idx = 4'(idx);
        exp_q.push_back(exp);
        tick();
        check(tag, 32'(b.trace_rd_data), exp_q.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a.src_data = '0; a.src_en = '0; a.err_clear = 0; a.trace_en = 0; a.trace_clear = 0; a.trace_rd_idx = '0;
        b.src_data = '0; b.src_en = '0; b.err_clear = 0; b.trace_en = 0; b.trace_clear = 0; b.trace_rd_idx = '0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_sticky", 32'(a.contention_sticky), 0);
        check("rst_count", 32'(a.trace_count), 0);
        check("rst_ovf", 32'(a.trace_overflow), 0);
        check("rst_rd", 32'(a.trace_rd_data), 0);
        check("rst_full", 32'(a.trace_full), 0);

        // Priority resolve and first-contention capture.
        a.src_data[2*16 +: 16] = 16'h00AA;
        a.src_data[4*16 +: 16] = 16'h1234;
        a.src_en = 8'b0001_0100;
        #1;
        check("pri_bus", 32'(a.bus), 32'h00AA);
        check("pri_cont", 32'(a.contention), 1);
        check("pri_valid", 32'(a.bus_valid), 1);
        tick();
        check("sticky_set", 32'(a.contention_sticky), 1);
        check("cont_src", 32'(a.contention_src), 32'h14);
        a.src_en = 8'b0001_1000;
        tick();
        check("cont_src_hold", 32'(a.contention_src), 32'h14);
        a.src_en = 8'b0001_0100;
        a.err_clear = 1;
        tick();
        check("errclr_sticky", 32'(a.contention_sticky), 0);
        check("errclr_src", 32'(a.contention_src), 0);
        a.err_clear = 0;
        a.src_en = 8'b0000_0100;
        #1;
        check("single_cont", 32'(a.contention), 0);

        // OR resolve on the second instance.
        b.src_data[0 +: 16]  = 16'h00F0;
        b.src_data[16 +: 16] = 16'h000F;
        b.src_en = 8'b0000_0011;
        #1;
        check("or_bus", 32'(b.bus), 32'h00FF);
        b.src_en = '0;
        #1;
        check("idle_bus", 32'(b.bus), 0);
        check("idle_valid", 32'(b.bus_valid), 0);

        // Fill both traces with 1..20: instance a wraps, instance b stops.
        a.src_data = '0;
        b.src_data = '0;
        a.src_en = 8'h01; b.src_en = 8'h01;
        a.trace_en = 1;   b.trace_en = 1;
        for (int v = 1; v <= 20; v++) begin
            a.src_data[0 +: 16] = 16'(v);
            b.src_data[0 +: 16] = 16'(v);
            tick();
        end
        a.trace_en = 0; b.trace_en = 0;
        check("wrap_count", 32'(a.trace_count), 16);
        check("wrap_full", 32'(a.trace_full), 1);
        check("wrap_ovf", 32'(a.trace_overflow), 1);
        for (int i = 0; i < 16; i++) read_a(i, 32'(i + 5), $sformatf("wrap_idx%0d", i));
        check("stop_count", 32'(b.trace_count), 16);
        check("stop_ovf", 32'(b.trace_overflow), 1);
        read_b(0, 1, "stop_idx0");
        read_b(15, 16, "stop_idx15");
        b.trace_clear = 1;
        tick();
        b.trace_clear = 0;
        check("clr_count", 32'(b.trace_count), 0);
        check("clr_ovf", 32'(b.trace_overflow), 0);
        read_b(0, 0, "clr_idx0");

        // Read-before-write on the 4th capture, then clear racing a capture.
        a.trace_clear = 1;
        tick();
        a.trace_clear = 0;
        a.trace_en = 1;
        for (int v = 1; v <= 3; v++) begin
            a.src_data[0 +: 16] = 16'(v * 16'h10);
            tick();
        end
        a.src_data[0 +: 16] = 16'h0040;
        read_a(2, 32'h30, "rbw_idx2");
        a.trace_en = 0;
        check("rbw_count", 32'(a.trace_count), 4);
        read_a(3, 32'h40, "rbw_idx3");
        read_a(5, 0, "beyond_count");
        a.trace_en = 1;
        a.trace_clear = 1;
        tick();
        a.trace_clear = 0;
        a.trace_en = 0;
        check("clr_cap_count", 32'(a.trace_count), 0);

        // Reset in the middle of activity.
        a.trace_en = 1;
        for (int v = 0; v < 7; v++) begin
            a.src_data[0 +: 16] = 16'(16'h100 + v);
            tick();
        end
        a.trace_en = 0;
        a.src_data[2*16 +: 16] = 16'h00AA;
        a.src_en = 8'b0000_0101;
        read_a(0, 32'h100, "pre_rst_idx0");
        check("pre_rst_sticky", 32'(a.contention_sticky), 1);
        a.src_en = 8'h01;
        a.src_data[0 +: 16] = 16'h0077;
        a.trace_en = 1;
        rst = 1;
        tick();
        rst = 0;
        a.trace_en = 0;
        check("mid_rst_sticky", 32'(a.contention_sticky), 0);
        check("mid_rst_src", 32'(a.contention_src), 0);
        check("mid_rst_count", 32'(a.trace_count), 0);
        check("mid_rst_ovf", 32'(a.trace_overflow), 0);
        check("mid_rst_rd", 32'(a.trace_rd_data), 0);
        a.src_data[0 +: 16] = 16'hBEEF;
        a.trace_en = 1;
        tick();
        a.trace_en = 0;
        check("post_rst_count", 32'(a.trace_count), 1);
        read_a(0, 32'hBEEF, "post_rst_idx0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
Parametrised shared-bus fabric for the CPU datapath. It generalises the fixed one-hot bus multiplexer to NUM_SRC sources of WIDTH bits, with a selectable resolve mode and contention detection that records the offending enables. A trace buffer captures the bus value on every active cycle. The buffer is read by index so the board LEDs and seven-segment display can replay recent bus history after a halt.

Parameters:
WIDTH, 16, bit width of each source and of the bus
NUM_SRC, 8, number of bus drivers (>=2)
TRACE_DEPTH, 16, trace entries; power of two, >=2
PRIORITY_MODE, 1, 1 = lowest-index enabled source wins; 0 = bitwise OR of all enabled sources
TRACE_STOP_ON_FULL, 0, 0 = wrap and overwrite oldest entry; 1 = stop capturing when full

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
src_data  input  NUM_SRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
src_en  input  NUM_SRC  drive enable per source
bus  output  WIDTH  resolved bus value (combinational)
bus_valid  output  1  at least one src_en bit set (combinational)
contention  output  1  more than one src_en bit set this cycle (combinational)
contention_sticky  output  1  latched contention flag
contention_src  output  NUM_SRC  src_en snapshot at the first contention
err_clear  input  1  clears contention_sticky and contention_src
trace_en  input  1  capture enable
trace_clear  input  1  empties the trace buffer
trace_rd_idx  input  log2(TRACE_DEPTH)  read index; 0 = oldest valid entry
trace_rd_data  output  WIDTH  registered read data
trace_count  output  log2(TRACE_DEPTH)+1  number of valid entries
trace_full  output  1  trace_count == TRACE_DEPTH
trace_overflow  output  1  sticky; set when a capture is dropped or overwrites an entry

Behaviour:
- Resolve, PRIORITY_MODE=1: bus = data of the lowest-index source with en=1.
- Resolve, PRIORITY_MODE=0: bus = OR of the data of all enabled sources.
- No enables: bus = 0, bus_valid = 0.
- contention = (popcount(src_en) > 1); it is independent of mode.
- Contention latch, on a clk edge:
  - err_clear=1: contention_sticky <= 0 and contention_src <= 0. err_clear beats a simultaneous contention.
  - Else if contention=1 and contention_sticky=0: contention_sticky <= 1 and contention_src <= src_en.
  - Later contentions leave contention_src unchanged.
- Trace state: write pointer wr_ptr (mod TRACE_DEPTH), count (saturates at TRACE_DEPTH), memory array.
- Capture condition: trace_en & bus_valid & ~trace_clear.
  - Not full: mem[wr_ptr] <= bus, wr_ptr++, count++.
  - Full, TRACE_STOP_ON_FULL=0: write and advance wr_ptr, count stays, trace_overflow <= 1.
  - Full, TRACE_STOP_ON_FULL=1: no write, pointers unchanged, trace_overflow <= 1.
- trace_clear: wr_ptr <= 0, count <= 0, trace_overflow <= 0. Any capture in the same cycle is discarded. Memory contents are not cleared.
- Read is 1-cycle latency: trace_rd_data at edge n+1 reflects trace_rd_idx and state sampled at edge n.
  - Physical address = (base + idx) mod TRACE_DEPTH, where base = wr_ptr if count == TRACE_DEPTH, else 0.
  - idx >= count: returns 0.
  - Read-before-write: a read and a capture on the same edge return pre-capture contents and use pre-capture base/count.
  - A same-edge trace_clear does not affect the read issued on that edge.
- trace_full = (count == TRACE_DEPTH); it is combinational from count.
- Reset (synchronous, highest priority) sets all of the following to 0 one edge after rst is sampled high, including mid-capture: contention_sticky, contention_src, wr_ptr, count, trace_overflow, trace_rd_data.
  - Memory contents are not reset.
  - Combinational outputs follow their inputs during reset.
- All index arithmetic wraps modulo TRACE_DEPTH; no out-of-range memory access is possible.

Test Plan:
- Priority mode, WIDTH=16: src_en=8'b0001_0100, src2=16'h00AA, src4=16'h1234 -> bus=16'h00AA, contention=1. Next edge: contention_sticky=1, contention_src=8'h14.
- OR mode: src_en=8'b0000_0011, src0=16'h00F0, src1=16'h000F -> bus=16'h00FF. Then src_en=0 -> bus=0, bus_valid=0.
- Trace fill, wrap mode, depth 16: capture 1..20 on consecutive cycles.
  - Expect trace_count=16, trace_full=1, trace_overflow=1.
  - idx 0 -> 5 and idx 15 -> 20, each one cycle after presenting the index.
- Stop mode, depth 16: capture 1..20 -> idx 0 -> 1, idx 15 -> 16, trace_overflow=1. trace_clear -> count=0, overflow=0, idx 0 -> 0.
- Simultaneous events:
  - Read idx 2 on the same edge as the 4th capture (count=3) -> returns the 3rd value.
  - trace_clear with capture asserted -> count=0.
  - err_clear with contention on the same edge -> contention_sticky=0.
- Reset mid-operation: after 7 captures and a contention, pulse rst for one edge.
  - All registered outputs = 0 and count=0.
  - The next capture lands at idx 0.
